// File: rtl/lms_sync_prefetch_fifo_if.sv
// -----------------------------------------------------------------------------
// lms_sync_prefetch_fifo_if
// Handshake bundle between the sample source / LMS core and the prefetch FIFO.
//   master : the side that pushes and pops (drives flush, wr_en, wr_data, rd_en)
//   slave  : the FIFO itself (drives wr_vld, rd_data, rd_vld, level and flags)
// Signals:
//   flush        synchronous clear of contents and flags
//   wr_en/wr_data/wr_vld   write request, data, write ready
//   rd_en/rd_data/rd_vld   pop request, head-of-queue data, head valid
//   level        words accepted and not yet popped (DEPTH_WIDTH+1 bits)
//   almost_full, almost_empty, overflow, underflow   status flags
// -----------------------------------------------------------------------------
interface lms_sync_prefetch_fifo_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH_WIDTH = 11
);
   logic                   flush;
   logic                   wr_en;
   logic [DATA_WIDTH-1:0]  wr_data;
   logic                   wr_vld;
   logic                   rd_en;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   rd_vld;
   logic [DEPTH_WIDTH:0]   level;
   logic                   almost_full;
   logic                   almost_empty;
   logic                   overflow;
   logic                   underflow;

   modport master (
      output flush, wr_en, wr_data, rd_en,
      input  wr_vld, rd_data, rd_vld, level,
             almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en,
      output wr_vld, rd_data, rd_vld, level,
             almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/lms_sync_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// lms_sync_prefetch_fifo
// Single-clock first-word-fall-through FIFO for the LMS audio path.
// Storage is a simple-dual-port RAM with a registered (1-cycle) read port; a
// prefetch output register presents the head word so rd_data is valid whenever
// rd_vld is high.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  lms_sync_prefetch_fifo_if.slave (handshake, level and status flags)
// -----------------------------------------------------------------------------
module lms_sync_prefetch_fifo #(
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH_WIDTH = 11,
   parameter int AF_TH       = (1 << DEPTH_WIDTH) - 4,
   parameter int AE_TH       = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   lms_sync_prefetch_fifo_if.slave   bus
);

   localparam int                   CAP_N   = 1 << DEPTH_WIDTH;
   localparam logic [DEPTH_WIDTH:0] CAP     = {1'b1, {DEPTH_WIDTH{1'b0}}};
   localparam logic [DEPTH_WIDTH:0] AF_L    = AF_TH[DEPTH_WIDTH:0];
   localparam logic [DEPTH_WIDTH:0] AE_L    = AE_TH[DEPTH_WIDTH:0];
   localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_WIDTH:0]   CNT_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0]  mem_q [0:CAP_N-1];
   logic [DATA_WIDTH-1:0]  ram_dout_q;

   logic [DEPTH_WIDTH-1:0] wptr_q, wptr_d;
   logic [DEPTH_WIDTH-1:0] rptr_q, rptr_d;
   logic [DEPTH_WIDTH:0]   ram_cnt_q, ram_cnt_d;   // words in RAM not yet issued
   logic [DEPTH_WIDTH:0]   level_q, level_d;
   logic                   mid_vld_q, mid_vld_d;   // RAM read port holds an unconsumed word
   logic                   out_vld_q, out_vld_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic                   af_q, af_d;
   logic                   ae_q, ae_d;
   logic                   ovf_q, ovf_d;
   logic                   udf_q, udf_d;

   logic                   wr_vld;
   logic                   wr_acc;
   logic                   rd_acc;
   logic                   move;
   logic                   issue;

   // Handshake decode. wr_vld comes only from the registered level, so a pop in
   // the same cycle never opens a slot for a write.
   always_comb begin
      wr_vld = (level_q < CAP);
      wr_acc = bus.wr_en && wr_vld && !bus.flush;
      rd_acc = bus.rd_en && out_vld_q && !bus.flush;
      // RAM read-port word moves into the output register when it is free or
      // being popped at this edge.
      move   = mid_vld_q && (!out_vld_q || rd_acc);
      // A new RAM read may issue only if the read-port register will be free,
      // which keeps the returned word from overwriting an unconsumed one.
      issue  = (ram_cnt_q != '0) && (!mid_vld_q || move) && !bus.flush;
   end

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      ram_cnt_d  = ram_cnt_q;
      level_d    = level_q;
      mid_vld_d  = mid_vld_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;

      if (bus.flush) begin
         wptr_d     = '0;
         rptr_d     = '0;
         ram_cnt_d  = '0;
         level_d    = '0;
         mid_vld_d  = 1'b0;
         out_vld_d  = 1'b0;
         out_data_d = '0;
         ovf_d      = 1'b0;
         udf_d      = 1'b0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + PTR_ONE;
         if (issue)  rptr_d = rptr_q + PTR_ONE;

         case ({wr_acc, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
         endcase

         case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + CNT_ONE;
            2'b01:   level_d = level_q - CNT_ONE;
            default: level_d = level_q;
         endcase

         if (issue)     mid_vld_d = 1'b1;
         else if (move) mid_vld_d = 1'b0;

         if (move) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_dout_q;
         end else if (rd_acc) begin
            out_vld_d  = 1'b0;
         end

         ovf_d = ovf_q | (bus.wr_en && !wr_vld);
         udf_d = udf_q | (bus.rd_en && !out_vld_q);
      end

      // Thresholds are evaluated on the next level so the registered flags
      // line up with the registered level.
      af_d = (level_d >= AF_L);
      ae_d = (level_d <= AE_L);
   end

   // Storage RAM: write port and registered read port (held when not issuing).
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wptr_q] <= bus.wr_data;
      if (issue)  ram_dout_q    <= mem_q[rptr_q];
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         ram_cnt_q  <= '0;
         level_q    <= '0;
         mid_vld_q  <= 1'b0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         ram_cnt_q  <= ram_cnt_d;
         level_q    <= level_d;
         mid_vld_q  <= mid_vld_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         af_q       <= af_d;
         ae_q       <= ae_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   assign bus.wr_vld       = wr_vld;
   assign bus.rd_vld       = out_vld_q;
   assign bus.rd_data      = out_data_q;
   assign bus.level        = level_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_lms_sync_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// tb_lms_sync_prefetch_fifo
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized phase, all compared against a queue-based reference model.
// The model treats the FIFO as an ordered list of (word, accept-edge) pairs;
// the head word becomes visible two edges after it was accepted.
// -----------------------------------------------------------------------------
module tb_lms_sync_prefetch_fifo;

   localparam int DW  = 16;
   localparam int AW  = 11;
   localparam int CAP = 1 << AW;
   localparam int AF  = CAP - 4;
   localparam int AE  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lms_sync_prefetch_fifo_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bus ();

   lms_sync_prefetch_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH_WIDTH(AW),
      .AF_TH      (AF),
      .AE_TH      (AE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   typedef struct {
      logic [DW-1:0] d;
      int            t;
   } ent_t;
   ent_t mq[$];
   int   edge_cnt = 0;
   logic m_ovf = 1'b0;
   logic m_udf = 1'b0;

   typedef struct {
      logic          f;
      logic          we;
      logic [DW-1:0] wd;
      logic          re;
      logic          e_vld;
      logic [DW-1:0] e_data;
      int            e_lvl;
      logic          e_ae;
      logic          e_udf;
   } vec_t;
   vec_t tbl [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", nm, act, exp, edge_cnt);
   endtask

   function automatic logic m_rdvld();
      return (mq.size() > 0) && (mq[0].t + 2 <= edge_cnt);
   endfunction

   task automatic check_model();
      int lv;
      lv = mq.size();
      chk("level",        32'(bus.level),        32'(lv));
      chk("wr_vld",       32'(bus.wr_vld),       32'(lv < CAP));
      chk("rd_vld",       32'(bus.rd_vld),       32'(m_rdvld()));
      if (m_rdvld()) chk("rd_data", 32'(bus.rd_data), 32'(mq[0].d));
      chk("almost_full",  32'(bus.almost_full),  32'(lv >= AF));
      chk("almost_empty", 32'(bus.almost_empty), 32'(lv <= AE));
      chk("overflow",     32'(bus.overflow),     32'(m_ovf));
      chk("underflow",    32'(bus.underflow),    32'(m_udf));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_level"},  32'(bus.level),        32'd0);
      chk({tag, "_rd_vld"}, 32'(bus.rd_vld),       32'd0);
      chk({tag, "_rd_data"},32'(bus.rd_data),      32'd0);
      chk({tag, "_wr_vld"}, 32'(bus.wr_vld),       32'd1);
      chk({tag, "_ae"},     32'(bus.almost_empty), 32'd1);
      chk({tag, "_af"},     32'(bus.almost_full),  32'd0);
      chk({tag, "_ovf"},    32'(bus.overflow),     32'd0);
      chk({tag, "_udf"},    32'(bus.underflow),    32'd0);
   endtask

   // One clock: drive inputs, advance the model across the edge, compare.
   task automatic cycle(input logic f, input logic we, input logic [DW-1:0] wd, input logic re);
      logic wv, rv, wa, ra;
      bus.flush   = f;
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.rd_en   = re;
      wv = (mq.size() < CAP);
      rv = m_rdvld();
      wa = we && wv && !f;
      ra = re && rv && !f;
      @(posedge clk);
      edge_cnt++;
      if (f) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (ra) mq.delete(0);
         if (wa) mq.push_back('{wd, edge_cnt});
         if (we && !wv) m_ovf = 1'b1;
         if (re && !rv) m_udf = 1'b1;
      end
      #1;
      check_model();
   endtask

   // Structural invariants, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("inv_level_le_cap", 32'(int'(bus.level) <= CAP), 32'd1);
         chk("inv_wr_vld",       32'(bus.wr_vld), 32'(int'(bus.level) < CAP));
         chk("inv_rd_vld_low",   32'(bus.rd_vld || (int'(bus.level) <= 2)), 32'd1);
      end
   end

   initial begin
      int bubbles;
      int wp, rp;
      logic f, we, re;

      rst         = 1'b1;
      bus.flush   = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;

      // ---------------- reset
      repeat (2) @(posedge clk);
      #1;
      check_reset("por");
      rst = 1'b0;

      // ---------------- directed vector table
      tbl[0]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 1, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 2, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 16'h0001, 3, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 16'h0004, 1'b0, 1'b1, 16'h0001, 4, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 3, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 2, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h0004, 2, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0};

      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].f, tbl[i].we, tbl[i].wd, tbl[i].re);
         chk($sformatf("tbl%0d_rd_vld", i), 32'(bus.rd_vld), 32'(tbl[i].e_vld));
         if (tbl[i].e_vld)
            chk($sformatf("tbl%0d_rd_data", i), 32'(bus.rd_data), 32'(tbl[i].e_data));
         chk($sformatf("tbl%0d_level", i), 32'(bus.level), 32'(tbl[i].e_lvl));
         chk($sformatf("tbl%0d_ae", i), 32'(bus.almost_empty), 32'(tbl[i].e_ae));
         chk($sformatf("tbl%0d_udf", i), 32'(bus.underflow), 32'(tbl[i].e_udf));
      end

      // ---------------- fill to capacity, then one extra write
      for (int i = 0; i < CAP; i++) begin
         cycle(1'b0, 1'b1, 16'(i) ^ 16'hA5A5, 1'b0);
         if (i == AF - 2) chk("fill_af_below", 32'(bus.almost_full), 32'd0);
         if (i == AF - 1) chk("fill_af_at",    32'(bus.almost_full), 32'd1);
      end
      chk("full_wr_vld", 32'(bus.wr_vld), 32'd0);
      cycle(1'b0, 1'b1, 16'hDEAD, 1'b0);
      chk("full_level",    32'(bus.level),       32'(CAP));
      chk("full_overflow", 32'(bus.overflow),    32'd1);
      chk("full_af",       32'(bus.almost_full), 32'd1);
      // Pop while writing at full: the write must still be refused.
      cycle(1'b0, 1'b1, 16'hBEEF, 1'b1);
      chk("full_pop_level", 32'(bus.level), 32'(CAP - 1));
      // Drain everything; the model verifies order and the missing extra word.
      for (int i = 0; i < CAP + 2; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
      chk("drain_level", 32'(bus.level), 32'd0);

      // ---------------- continuous simultaneous write/read across pointer wrap
      cycle(1'b1, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'($urandom), 1'b0);
      bubbles = 0;
      for (int i = 0; i < 3 * CAP; i++) begin
         cycle(1'b0, 1'b1, 16'($urandom), 1'b1);
         if (!bus.rd_vld) bubbles++;
      end
      chk("stream_bubbles", 32'(bubbles), 32'd0);
      chk("stream_level",   32'(bus.level), 32'd8);

      // ---------------- flush at level 100 with wr_en and rd_en high
      cycle(1'b1, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 16'(i + 300), 1'b0);
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("pre_flush_level", 32'(bus.level), 32'd100);
      cycle(1'b1, 1'b1, 16'h1234, 1'b1);
      chk("flush_level",  32'(bus.level),     32'd0);
      chk("flush_rd_vld", 32'(bus.rd_vld),    32'd0);
      chk("flush_ovf",    32'(bus.overflow),  32'd0);
      chk("flush_udf",    32'(bus.underflow), 32'd0);
      cycle(1'b0, 1'b1, 16'hBEEF, 1'b0);
      chk("post_flush_vld0", 32'(bus.rd_vld), 32'd0);
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("post_flush_vld1", 32'(bus.rd_vld), 32'd0);
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("post_flush_vld2", 32'(bus.rd_vld),  32'd1);
      chk("post_flush_data", 32'(bus.rd_data), 32'hBEEF);

      // ---------------- asynchronous reset mid-burst
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 16'($urandom), 1'(i % 2));
      #3;
      rst = 1'b1;
      #1;
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check_reset("arst");
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_reset("arst_hold");
      #2;
      rst = 1'b0;
      cycle(1'b0, 1'b1, 16'h7777, 1'b0);
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      chk("arst_first_vld",  32'(bus.rd_vld),  32'd1);
      chk("arst_first_data", 32'(bus.rd_data), 32'h7777);

      // ---------------- randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if (((i / 1000) % 2) == 0) begin wp = 80; rp = 45; end
         else                       begin wp = 45; rp = 80; end
         f  = ($urandom_range(0, 199) == 0);
         we = ($urandom_range(0, 99) < wp);
         re = ($urandom_range(0, 99) < rp);
         cycle(f, we, 16'($urandom), re);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
